// File: rtl/tema_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tema_result_fifo
// Brief    : Capture FIFO for the 3-bit datapath results (word + carry).
//            Valid/ready readout, registered head, no fall-through. Words
//            arriving while full are discarded and flagged by a sticky drop.
//            Optional carry_cnt output enabled by macro TEMA_FIFO_CARRY_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tema_result_fifo #(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_carry,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_carry,
  output logic [ADDR_W:0]   count,
  output logic              drop
`ifdef TEMA_FIFO_CARRY_CNT_EN
  ,
  output logic [7:0]        carry_cnt
`endif
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_PTR = ADDR_W'(1);

  logic [WIDTH-1:0]  data_mem  [DEPTH];
  logic              carry_mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Status flags come only from the registered occupancy, so they are glitch-free
  // and a same-cycle pop never opens the door for a push while full.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;

  assign out_data  = data_mem[rd_ptr];
  assign out_carry = carry_mem[rd_ptr];

  // Storage write; cleared only by reset, a flush leaves contents stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i]  <= '0;
        carry_mem[i] <= 1'b0;
      end
    end else if (!clr && push) begin
      data_mem[wr_ptr]  <= in_data;
      carry_mem[wr_ptr] <= in_carry;
    end
  end

  // Pointers and occupancy; flush overrides any transfer in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_PTR;
      if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      if (push && !pop)      count <= count + ONE_CNT;
      else if (pop && !push) count <= count - ONE_CNT;
    end
  end

  // Sticky loss flag: any word offered while full is discarded and remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drop <= 1'b0;
    else if (clr)             drop <= 1'b0;
    else if (in_valid && full) drop <= 1'b1;
  end

`ifdef TEMA_FIFO_CARRY_CNT_EN
  // Saturating count of accepted words that carried a carry bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         carry_cnt <= '0;
    else if (clr)                                    carry_cnt <= '0;
    else if (push && in_carry && carry_cnt != 8'hFF) carry_cnt <= carry_cnt + 8'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tema_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_tema_result_fifo
// Brief    : Directed self-checking bench for tema_result_fifo with a
//            queue-based reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tema_result_fifo;

  localparam int WIDTH  = 3;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_carry = 1'b0;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_carry;
  logic [ADDR_W:0]   count;
  logic              drop;
`ifdef TEMA_FIFO_CARRY_CNT_EN
  logic [7:0]        carry_cnt;
`endif

  int applied = 0;
  int miscompares = 0;

  tema_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_carry  (in_carry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .count     (count),
    .drop      (drop)
`ifdef TEMA_FIFO_CARRY_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {carry,data} plus sticky drop and carry count.
  logic [WIDTH:0] mq[$];
  bit             m_drop = 1'b0;
  int             m_ccnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_drop = 1'b0;
      m_ccnt = 0;
    end else if (clr) begin
      mq.delete();
      m_drop = 1'b0;
      m_ccnt = 0;
    end else begin
      bit was_full, do_push, do_pop;
      was_full = (mq.size() == DEPTH);
      do_push  = in_valid && !was_full;
      do_pop   = out_ready && (mq.size() != 0);
      if (in_valid && was_full) m_drop = 1'b1;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({in_carry, in_data});
        if (in_carry && m_ccnt < 255) m_ccnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", int'(out_valid), int'(mq.size() != 0));
    chk("in_ready",  int'(in_ready),  int'(mq.size() != DEPTH));
    chk("count",     int'(count),     mq.size());
    chk("drop",      int'(drop),      int'(m_drop));
    if (mq.size() != 0) begin
      chk("out_data",  int'(out_data),  int'(mq[0][WIDTH-1:0]));
      chk("out_carry", int'(out_carry), int'(mq[0][WIDTH]));
    end
`ifdef TEMA_FIFO_CARRY_CNT_EN
    chk("carry_cnt", int'(carry_cnt), m_ccnt);
`endif
  end

  // Apply one cycle of inputs; returns shortly after the following falling edge.
  task automatic drive(input bit v, input int d, input bit c, input bit r, input bit cl);
    in_valid  = v;
    in_data   = WIDTH'(d);
    in_carry  = c;
    out_ready = r;
    clr       = cl;
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_count",     int'(count),     0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_drop",      int'(drop),      0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Single push into empty FIFO: visible one cycle later
    drive(1, 5, 1, 0, 0);
    chk("push1_valid", int'(out_valid), 1);
    chk("push1_data",  int'(out_data),  5);
    chk("push1_carry", int'(out_carry), 1);
    chk("push1_count", int'(count),     1);
`ifdef TEMA_FIFO_CARRY_CNT_EN
    chk("push1_ccnt",  int'(carry_cnt), 1);
`endif
    drive(0, 0, 0, 1, 0);
    chk("pop1_count", int'(count), 0);

    // Overfill: 5 pushes, fifth is lost
    for (int i = 1; i <= 5; i++) drive(1, i, i[0], 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("full_count", int'(count),    4);
    chk("full_ready", int'(in_ready), 0);
    chk("full_drop",  int'(drop),     1);
    for (int i = 1; i <= 4; i++) begin
      chk("order_data", int'(out_data), i);
      drive(0, 0, 0, 1, 0);
    end
    chk("drained_valid", int'(out_valid), 0);
    drive(0, 0, 0, 1, 0);  // pop on empty is ignored
    chk("empty_pop_count", int'(count), 0);

    // Full with simultaneous offer and pop: pop only
    for (int i = 6; i <= 9; i++) drive(1, i, 0, 0, 0);
    chk("refill_count", int'(count), 4);
    drive(1, 2, 1, 1, 0);
    chk("fullpop_count", int'(count), 3);
    chk("fullpop_drop",  int'(drop),  1);
    chk("fullpop_head",  int'(out_data), 7);

    // Flush with count=2 and drop set
    drive(0, 0, 0, 1, 0);
    chk("preclr_count", int'(count), 2);
    drive(1, 3, 1, 1, 1);
    chk("clr_count", int'(count),     0);
    chk("clr_valid", int'(out_valid), 0);
    chk("clr_drop",  int'(drop),      0);
`ifdef TEMA_FIFO_CARRY_CNT_EN
    chk("clr_ccnt",  int'(carry_cnt), 0);
`endif

    // Streaming push+pop across two pointer wraps
    drive(1, 4, 1, 0, 0);
    chk("stream_head", int'(out_data), 4);
`ifdef TEMA_FIFO_CARRY_CNT_EN
    chk("stream_ccnt", int'(carry_cnt), 1);
`endif
    for (int i = 0; i < 10; i++) begin
      drive(1, i, i[1], 1, 0);
      chk("stream_count", int'(count), 1);
      chk("stream_data",  int'(out_data), i % 8);
    end
    chk("stream_drop", int'(drop), 0);

    // Async reset mid-stream at count=3
    drive(1, 6, 0, 0, 0);
    drive(1, 3, 1, 0, 0);
    chk("pre_rst_count", int'(count), 3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_count", int'(count),     0);
    chk("arst_data",  int'(out_data),  0);
    chk("arst_ready", int'(in_ready),  1);
    chk("arst_drop",  int'(drop),      0);
    @(negedge clk); #1;
    rst = 1'b0;
    drive(1, 2, 0, 0, 0);
    chk("post_rst_data", int'(out_data), 2);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
